// File: rtl/fpu_regfile_mp_if.sv
// Register file bus: writeback commit ports, read ports and scoreboard control.
// The master side is the pipeline (issue/writeback); the slave side is the register file.
interface fpu_regfile_mp_if #(
  parameter int REG_NUM    = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FMT_WIDTH  = 3,
  parameter int N_RD       = 4,
  parameter int N_WR       = 2
);
  localparam int AW = $clog2(REG_NUM);

  logic [N_WR-1:0]                 wr_we;
  logic [N_WR-1:0][AW-1:0]         wr_addr;
  logic [N_WR-1:0][DATA_WIDTH-1:0] wr_data;
  logic [N_WR-1:0][FMT_WIDTH-1:0]  wr_fmt;
  logic [N_RD-1:0][AW-1:0]         rd_addr;
  logic [N_RD-1:0][DATA_WIDTH-1:0] rd_data;
  logic [N_RD-1:0][FMT_WIDTH-1:0]  rd_fmt;
  logic [N_RD-1:0]                 rd_busy;
  logic                            sb_set;
  logic [AW-1:0]                   sb_addr;
  logic                            sb_flush;
  logic                            init_done;

  modport master (
    output wr_we, wr_addr, wr_data, wr_fmt, rd_addr, sb_set, sb_addr, sb_flush,
    input  rd_data, rd_fmt, rd_busy, init_done
  );

  modport slave (
    input  wr_we, wr_addr, wr_data, wr_fmt, rd_addr, sb_set, sb_addr, sb_flush,
    output rd_data, rd_fmt, rd_busy, init_done
  );
endinterface

// File: rtl/fpu_regfile_mp.sv
// Multi-port FPU register file with format tags, same-cycle write bypass,
// pending-write scoreboard and a one-register-per-cycle clear after reset.

// One read port: bypass from the highest-index matching write, masked to zero outside RUN.
module fpu_regfile_mp_rdport #(
  parameter int N_WR        = 2,
  parameter int AW          = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int FMT_WIDTH   = 3,
  parameter int FMT_UNKNOWN = 0
) (
  input  logic                            run_i,
  input  logic [AW-1:0]                   addr_i,
  input  logic [N_WR-1:0]                 wr_we_i,
  input  logic [N_WR-1:0][AW-1:0]         wr_addr_i,
  input  logic [N_WR-1:0][DATA_WIDTH-1:0] wr_data_i,
  input  logic [N_WR-1:0][FMT_WIDTH-1:0]  wr_fmt_i,
  input  logic [DATA_WIDTH-1:0]           st_data_i,
  input  logic [FMT_WIDTH-1:0]            st_fmt_i,
  input  logic                            st_busy_i,
  output logic [DATA_WIDTH-1:0]           data_o,
  output logic [FMT_WIDTH-1:0]            fmt_o,
  output logic                            busy_o
);
  logic hit;

  always_comb begin
    hit    = 1'b0;
    data_o = st_data_i;
    fmt_o  = st_fmt_i;
    for (int k = 0; k < N_WR; k++) begin
      if (wr_we_i[k] && wr_addr_i[k] == addr_i) begin
        hit    = 1'b1;
        data_o = wr_data_i[k];
        fmt_o  = wr_fmt_i[k];
      end
    end
    busy_o = st_busy_i & ~hit;
    if (!run_i) begin
      data_o = '0;
      fmt_o  = FMT_WIDTH'(FMT_UNKNOWN);
      busy_o = 1'b0;
    end
  end
endmodule

module fpu_regfile_mp #(
  parameter int REG_NUM     = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int FMT_WIDTH   = 3,
  parameter int FMT_UNKNOWN = 0,
  parameter int N_RD        = 4,
  parameter int N_WR        = 2
) (
  input logic            clk_i,
  input logic            rst_i,
  fpu_regfile_mp_if.slave bus
);
  localparam int AW = $clog2(REG_NUM);
  localparam logic [AW-1:0] LAST = AW'(REG_NUM - 1);

  typedef enum logic {INIT, RUN} state_e;

  state_e                  state_q;
  logic [AW-1:0]           cnt_q;
  logic                    init_done_q;
  logic [REG_NUM-1:0]      busy_q;
  logic [DATA_WIDTH-1:0]   data_q [REG_NUM];
  logic [FMT_WIDTH-1:0]    fmt_q  [REG_NUM];
  logic                    run;

  assign run           = (state_q == RUN) && !rst_i;
  assign bus.init_done = init_done_q;

  // Later loop iterations override earlier ones, giving the higher write port priority;
  // sb_set is applied after the write-clears so it wins on the same register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      busy_q      <= '0;
    end else begin
      case (state_q)
        INIT: begin
          data_q[cnt_q] <= '0;
          fmt_q[cnt_q]  <= FMT_WIDTH'(FMT_UNKNOWN);
          cnt_q         <= cnt_q + AW'(1);
          if (cnt_q == LAST) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end
        end
        RUN: begin
          for (int k = 0; k < N_WR; k++) begin
            if (bus.wr_we[k]) begin
              data_q[bus.wr_addr[k]] <= bus.wr_data[k];
              fmt_q[bus.wr_addr[k]]  <= bus.wr_fmt[k];
            end
          end
          if (bus.sb_flush) begin
            busy_q <= '0;
          end else begin
            for (int k = 0; k < N_WR; k++) begin
              if (bus.wr_we[k]) busy_q[bus.wr_addr[k]] <= 1'b0;
            end
            if (bus.sb_set) busy_q[bus.sb_addr] <= 1'b1;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  for (genvar i = 0; i < N_RD; i++) begin : g_rd
    fpu_regfile_mp_rdport #(
      .N_WR(N_WR), .AW(AW), .DATA_WIDTH(DATA_WIDTH),
      .FMT_WIDTH(FMT_WIDTH), .FMT_UNKNOWN(FMT_UNKNOWN)
    ) u_rd (
      .run_i     (run),
      .addr_i    (bus.rd_addr[i]),
      .wr_we_i   (bus.wr_we),
      .wr_addr_i (bus.wr_addr),
      .wr_data_i (bus.wr_data),
      .wr_fmt_i  (bus.wr_fmt),
      .st_data_i (data_q[bus.rd_addr[i]]),
      .st_fmt_i  (fmt_q[bus.rd_addr[i]]),
      .st_busy_i (busy_q[bus.rd_addr[i]]),
      .data_o    (bus.rd_data[i]),
      .fmt_o     (bus.rd_fmt[i]),
      .busy_o    (bus.rd_busy[i])
    );
  end
endmodule

// File: tb/tb_fpu_regfile_mp.sv
// Directed bench for fpu_regfile_mp: init sequence, bypass, write priority, scoreboard, reset mid-init.
module tb_fpu_regfile_mp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fpu_regfile_mp_if bus ();

  fpu_regfile_mp dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.wr_we    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.wr_fmt   = '0;
    bus.rd_addr  = '0;
    bus.sb_set   = 1'b0;
    bus.sb_addr  = '0;
    bus.sb_flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts posedges after rst drops until init_done rises; returns 999 on timeout.
  task automatic wait_init(output int n);
    n = 999;
    for (int c = 1; c <= 100; c++) begin
      step();
      if (bus.init_done === 1'b1) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    idle();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if (bus.init_done !== 1'b0) begin
      errors++; $display("FAIL reset_init_done got %b want 0", bus.init_done);
    end
    rst = 1'b0;
    wait_init(n);
    checks++;
    if (n !== 32) begin
      errors++; $display("FAIL init_cycles got %0d want 32", n);
    end
    for (int r = 0; r < 32; r += 4) begin
      for (int p = 0; p < 4; p++) bus.rd_addr[p] = 5'(r + p);
      #1;
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (bus.rd_data[p] !== 32'h0 || bus.rd_fmt[p] !== 3'd0 || bus.rd_busy[p] !== 1'b0) begin
          errors++;
          $display("FAIL post_init_read r%0d got %h/%0d/%b want 0/0/0",
                   r + p, bus.rd_data[p], bus.rd_fmt[p], bus.rd_busy[p]);
        end
      end
    end
    idle();
  endtask

  task automatic test_write_priority();
    bus.wr_we   = 2'b11;
    bus.wr_addr[0] = 5'd5; bus.wr_data[0] = 32'h3F800000; bus.wr_fmt[0] = 3'd1;
    bus.wr_addr[1] = 5'd5; bus.wr_data[1] = 32'h40000000; bus.wr_fmt[1] = 3'd2;
    bus.rd_addr[0] = 5'd5;
    #1;
    checks++;
    if (bus.rd_data[0] !== 32'h40000000 || bus.rd_fmt[0] !== 3'd2) begin
      errors++; $display("FAIL prio_bypass got %h/%0d want 40000000/2", bus.rd_data[0], bus.rd_fmt[0]);
    end
    step();
    bus.wr_we = '0;
    #1;
    checks++;
    if (bus.rd_data[0] !== 32'h40000000 || bus.rd_fmt[0] !== 3'd2) begin
      errors++; $display("FAIL prio_stored got %h/%0d want 40000000/2", bus.rd_data[0], bus.rd_fmt[0]);
    end
    idle();
  endtask

  task automatic test_bypass_all_ports();
    bus.wr_we = 2'b01;
    bus.wr_addr[0] = 5'd7; bus.wr_data[0] = 32'hDEADBEEF; bus.wr_fmt[0] = 3'd3;
    for (int p = 0; p < 4; p++) bus.rd_addr[p] = 5'd7;
    #1;
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (bus.rd_data[p] !== 32'hDEADBEEF || bus.rd_fmt[p] !== 3'd3) begin
        errors++; $display("FAIL bypass_port%0d got %h/%0d want deadbeef/3", p, bus.rd_data[p], bus.rd_fmt[p]);
      end
    end
    step();
    bus.wr_we = '0;
    bus.rd_addr[2] = 5'd5;
    #1;
    checks++;
    if (bus.rd_data[0] !== 32'hDEADBEEF || bus.rd_data[2] !== 32'h40000000) begin
      errors++; $display("FAIL stored_r7_r5 got %h,%h want deadbeef,40000000", bus.rd_data[0], bus.rd_data[2]);
    end
    idle();
  endtask

  task automatic test_scoreboard();
    bus.sb_set = 1'b1; bus.sb_addr = 5'd3;
    step();
    bus.sb_set = 1'b0;
    bus.rd_addr[0] = 5'd3; bus.rd_addr[1] = 5'd4;
    #1;
    checks++;
    if (bus.rd_busy[0] !== 1'b1 || bus.rd_busy[1] !== 1'b0) begin
      errors++; $display("FAIL sb_set got r3=%b r4=%b want 1,0", bus.rd_busy[0], bus.rd_busy[1]);
    end
    bus.wr_we = 2'b10; bus.wr_addr[1] = 5'd3; bus.wr_data[1] = 32'h12345678; bus.wr_fmt[1] = 3'd4;
    #1;
    checks++;
    if (bus.rd_busy[0] !== 1'b0) begin
      errors++; $display("FAIL sb_write_mask got %b want 0", bus.rd_busy[0]);
    end
    step();
    bus.wr_we = '0;
    #1;
    checks++;
    if (bus.rd_busy[0] !== 1'b0 || bus.rd_data[0] !== 32'h12345678 || bus.rd_fmt[0] !== 3'd4) begin
      errors++; $display("FAIL sb_cleared got %b/%h/%0d want 0/12345678/4", bus.rd_busy[0], bus.rd_data[0], bus.rd_fmt[0]);
    end
    idle();
  endtask

  task automatic test_sb_priority();
    bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
    bus.wr_we = 2'b01; bus.wr_addr[0] = 5'd9; bus.wr_data[0] = 32'hCAFEF00D; bus.wr_fmt[0] = 3'd5;
    step();
    bus.sb_set = 1'b1; bus.sb_addr = 5'd11;
    bus.wr_we = '0;
    bus.rd_addr[0] = 5'd9;
    #1;
    checks++;
    if (bus.rd_busy[0] !== 1'b1 || bus.rd_data[0] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL set_beats_write got %b/%h want 1/cafef00d", bus.rd_busy[0], bus.rd_data[0]);
    end
    step();
    bus.sb_flush = 1'b1; bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
    step();
    bus.sb_flush = 1'b0; bus.sb_set = 1'b0;
    bus.rd_addr[1] = 5'd11;
    #1;
    checks++;
    if (bus.rd_busy[0] !== 1'b0 || bus.rd_busy[1] !== 1'b0) begin
      errors++; $display("FAIL flush_beats_set got r9=%b r11=%b want 0,0", bus.rd_busy[0], bus.rd_busy[1]);
    end
    idle();
  endtask

  task automatic test_reset_mid_init();
    int n;
    bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    // Attempt writes and scoreboard updates throughout the clear sequence.
    bus.wr_we = 2'b11;
    bus.wr_addr[0] = 5'd12; bus.wr_data[0] = 32'h11111111; bus.wr_fmt[0] = 3'd6;
    bus.wr_addr[1] = 5'd31; bus.wr_data[1] = 32'h22222222; bus.wr_fmt[1] = 3'd7;
    bus.sb_set = 1'b1; bus.sb_addr = 5'd20;
    bus.rd_addr[0] = 5'd12;
    #1;
    checks++;
    if (bus.rd_data[0] !== 32'h0 || bus.rd_fmt[0] !== 3'd0 || bus.init_done !== 1'b0) begin
      errors++; $display("FAIL init_read_masked got %h/%0d done=%b want 0/0/0", bus.rd_data[0], bus.rd_fmt[0], bus.init_done);
    end
    wait_init(n);
    idle();
    checks++;
    if (n !== 32) begin
      errors++; $display("FAIL reinit_cycles got %0d want 32", n);
    end
    bus.rd_addr[0] = 5'd12; bus.rd_addr[1] = 5'd31; bus.rd_addr[2] = 5'd5; bus.rd_addr[3] = 5'd20;
    #1;
    checks++;
    if (bus.rd_data[0] !== 32'h0 || bus.rd_data[1] !== 32'h0 || bus.rd_fmt[1] !== 3'd0 ||
        bus.rd_data[2] !== 32'h0) begin
      errors++; $display("FAIL init_write_ignored got %h,%h,%h want 0,0,0", bus.rd_data[0], bus.rd_data[1], bus.rd_data[2]);
    end
    checks++;
    if (bus.rd_busy[3] !== 1'b0) begin
      errors++; $display("FAIL init_sb_ignored got %b want 0", bus.rd_busy[3]);
    end
    bus.rd_addr[3] = 5'd9;
    #1;
    checks++;
    if (bus.rd_busy[3] !== 1'b0) begin
      errors++; $display("FAIL rst_clears_busy got %b want 0", bus.rd_busy[3]);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_write_priority();
    test_bypass_all_ports();
    test_scoreboard();
    test_sb_priority();
    test_reset_mid_init();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
